// File: rtl/instr_ctrl_unit.sv
// Multi-cycle fetch/decode/execute/writeback controller for the ALU/register-file datapath.
// Optional feature macro: OVF_TRAP_EN (trap on signed overflow of ADD/ADDI/LI).
module instr_ctrl_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            instr_req,
  output logic [PC_W-1:0] pc,
  input  logic            instr_valid,
  input  logic [15:0]     instr,
  output logic [2:0]      rd0_addr,
  output logic [2:0]      rd1_addr,
  output logic [2:0]      wr_addr,
  output logic [3:0]      ALUOp,
  output logic            ALUSrc1,
  output logic            ALUSrc2,
  output logic [15:0]     alu_input2_instr_src,
  output logic            wr_en,
  output logic [15:0]     wr_data,
  input  logic [15:0]     result,
  input  logic            take_branch,
  input  logic            ovf,
  output logic            retire,
  output logic            illegal,
  output logic            halted,
  output logic            trap,
  output logic [2:0]      dbg_state
);

  // Fetch handshake: instr_req is high exactly while in FETCH; a word is accepted
  // on a rising edge where instr_req=1 and instr_valid=1. instr_valid is ignored otherwise.

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [15:0]     ir;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_nxt;
  logic [15:0]     result_q;
  logic            take_q;
  logic            ovf_q;

  // Registered decode results, held from EXEC through WB
  logic [2:0]  rd0_q, rd1_q, wra_q;
  logic [3:0]  alu_op_q;
  logic        src1_q, src2_q;
  logic [15:0] imm_q;
  logic        writes_q, branch_q, illegal_q, halt_q, ovf_chk_q;

  // Combinational decode of the instruction register
  logic [3:0]  op;
  logic [3:0]  dec_alu_op;
  logic        dec_src1, dec_src2;
  logic        dec_writes, dec_branch, dec_illegal, dec_halt, dec_ovf_chk;
  logic [15:0] dec_imm;

  logic ovf_trap;

`ifdef OVF_TRAP_EN
  assign ovf_trap = ovf_chk_q & ovf_q;
`else
  logic unused_ovf;
  assign ovf_trap   = 1'b0;
  assign unused_ovf = ^{ovf_q, ovf_chk_q};
`endif

  assign op      = ir[15:12];
  assign dec_imm = {{10{ir[5]}}, ir[5:0]};

  always_comb begin
    dec_alu_op  = op;
    dec_src1    = 1'b0;
    dec_src2    = 1'b0;
    dec_writes  = 1'b0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    dec_halt    = 1'b0;
    dec_ovf_chk = 1'b0;
    case (op)
      4'h0: begin
        dec_writes  = 1'b1;
        dec_ovf_chk = 1'b1;
      end
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8: dec_writes = 1'b1;
      4'h6, 4'h7: dec_branch = 1'b1;
      4'h9: begin
        dec_alu_op  = 4'h0;
        dec_src2    = 1'b1;
        dec_writes  = 1'b1;
        dec_ovf_chk = 1'b1;
      end
      4'hA: begin
        dec_alu_op  = 4'h0;
        dec_src1    = 1'b1;
        dec_src2    = 1'b1;
        dec_writes  = 1'b1;
        dec_ovf_chk = 1'b1;
      end
      4'hF: begin
        dec_alu_op = 4'h0;
        dec_halt   = 1'b1;
      end
      default: begin
        dec_alu_op  = 4'h0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Branch target is computed from the already sign-extended immediate, modulo 2**PC_W
  always_comb begin
    pc_nxt = pc_q + PC_W'(1);
    if (branch_q && take_q)
      pc_nxt = pc_q + PC_W'(1) + PC_W'($signed(imm_q));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (instr_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB: begin
        if (ovf_trap)    state_nxt = S_TRAP;
        else if (halt_q) state_nxt = S_HALT;
        else             state_nxt = S_FETCH;
      end
      S_HALT:   state_nxt = S_HALT;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ir        <= '0;
      pc_q      <= RESET_PC;
      result_q  <= '0;
      take_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rd0_q     <= '0;
      rd1_q     <= '0;
      wra_q     <= '0;
      alu_op_q  <= '0;
      src1_q    <= 1'b0;
      src2_q    <= 1'b0;
      imm_q     <= '0;
      writes_q  <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      halt_q    <= 1'b0;
      ovf_chk_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (instr_valid) ir <= instr;
        S_DECODE: begin
          rd0_q     <= ir[8:6];
          rd1_q     <= ir[5:3];
          wra_q     <= ir[11:9];
          alu_op_q  <= dec_alu_op;
          src1_q    <= dec_src1;
          src2_q    <= dec_src2;
          imm_q     <= dec_imm;
          writes_q  <= dec_writes;
          branch_q  <= dec_branch;
          illegal_q <= dec_illegal;
          halt_q    <= dec_halt;
          ovf_chk_q <= dec_ovf_chk;
        end
        S_EXEC: begin
          result_q <= result;
          take_q   <= take_branch;
          ovf_q    <= ovf;
        end
        S_WB: if (!ovf_trap) pc_q <= pc_nxt;
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    instr_req = (state == S_FETCH);
    wr_en     = (state == S_WB) && writes_q && !ovf_trap;
    retire    = (state == S_WB) && !ovf_trap;
    illegal   = (state == S_WB) && illegal_q;
    halted    = (state == S_HALT) || (state == S_TRAP);
`ifdef OVF_TRAP_EN
    trap      = (state == S_TRAP);
`else
    trap      = 1'b0;
`endif
  end

  assign pc                   = pc_q;
  assign rd0_addr             = rd0_q;
  assign rd1_addr             = rd1_q;
  assign wr_addr              = wra_q;
  assign ALUOp                = alu_op_q;
  assign ALUSrc1              = src1_q;
  assign ALUSrc2              = src2_q;
  assign alu_input2_instr_src = imm_q;
  assign wr_data              = result_q;
  assign dbg_state            = state;

endmodule

// File: tb/tb_instr_ctrl_unit.sv
// Directed bench for instr_ctrl_unit: drives fetch words and ALU responses, checks hand-computed outcomes.
module tb_instr_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req;
  logic [7:0]  pc;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic [2:0]  rd0_addr, rd1_addr, wr_addr;
  logic [3:0]  ALUOp;
  logic        ALUSrc1, ALUSrc2;
  logic [15:0] alu_input2_instr_src;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] result = '0;
  logic        take_branch = 1'b0;
  logic        ovf = 1'b0;
  logic        retire, illegal, halted, trap;
  logic [2:0]  dbg_state;

  int n_chk = 0;
  int n_bad = 0;

  // Observations captured by run_instr
  logic [3:0]  o_aluop;
  logic        o_src1, o_src2;
  logic [2:0]  o_rd0, o_rd1, o_wra;
  logic [15:0] o_imm;
  logic        o_wr_en, o_retire, o_illegal;
  logic [15:0] o_wr_data;
  logic [7:0]  o_pc;
  logic        o_req, o_halted, o_trap;
  logic [2:0]  o_state;
  int          wr_cnt, ret_cnt, bad_cyc;

  instr_ctrl_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .instr_req(instr_req), .pc(pc),
    .instr_valid(instr_valid), .instr(instr),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .wr_addr(wr_addr),
    .ALUOp(ALUOp), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
    .alu_input2_instr_src(alu_input2_instr_src),
    .wr_en(wr_en), .wr_data(wr_data), .result(result),
    .take_branch(take_branch), .ovf(ovf), .retire(retire),
    .illegal(illegal), .halted(halted), .trap(trap), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tally();
    if (wr_en)  wr_cnt++;
    if (retire) ret_cnt++;
  endtask

  // Called at a negedge; issues one word and steps through DECODE, EXEC, WB and the next cycle
  task automatic run_instr(input logic [15:0] word, input logic [15:0] res,
                           input logic tb_in, input logic ov_in);
    int waited = 0;
    while (!instr_req && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("req_wait", 32'(instr_req), 1);
    wr_cnt = 0;
    ret_cnt = 0;
    instr = word;
    instr_valid = 1'b1;
    result = res;
    take_branch = tb_in;
    ovf = ov_in;
    tally();
    @(negedge clk);
    instr_valid = 1'b0;
    tally();
    @(negedge clk);
    o_aluop = ALUOp; o_src1 = ALUSrc1; o_src2 = ALUSrc2;
    o_rd0 = rd0_addr; o_rd1 = rd1_addr; o_wra = wr_addr; o_imm = alu_input2_instr_src;
    tally();
    @(negedge clk);
    o_wr_en = wr_en; o_retire = retire; o_illegal = illegal; o_wr_data = wr_data;
    tally();
    @(negedge clk);
    o_pc = pc; o_req = instr_req; o_halted = halted; o_trap = trap; o_state = dbg_state;
    tally();
  endtask

  initial begin
    do_reset();
    check("rst_pc", 32'(pc), 'h00);
    check("rst_req", 32'(instr_req), 1);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_retire", 32'(retire), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_trap", 32'(trap), 0);
    check("rst_aluop", 32'(ALUOp), 0);
    check("rst_state", 32'(dbg_state), 0);

    // Stall: no instr_valid for 10 cycles
    bad_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!instr_req || pc != 8'h00 || dbg_state != 3'd0) bad_cyc++;
    end
    check("stall_hold", 32'(bad_cyc), 0);

    // LI r1,5
    run_instr(16'hA205, 16'h0005, 1'b0, 1'b0);
    check("li_aluop", 32'(o_aluop), 'h0);
    check("li_src1", 32'(o_src1), 1);
    check("li_src2", 32'(o_src2), 1);
    check("li_wra", 32'(o_wra), 1);
    check("li_imm", 32'(o_imm), 'h0005);
    check("li_wr_en", 32'(o_wr_en), 1);
    check("li_wr_data", 32'(o_wr_data), 'h0005);
    check("li_retire", 32'(o_retire), 1);
    check("li_wr_cnt", 32'(wr_cnt), 1);
    check("li_ret_cnt", 32'(ret_cnt), 1);
    check("li_pc", 32'(o_pc), 'h01);
    check("li_req", 32'(o_req), 1);

    // ADD r3,r1,r2
    run_instr(16'h0650, 16'h000C, 1'b0, 1'b0);
    check("add_aluop", 32'(o_aluop), 'h0);
    check("add_rd0", 32'(o_rd0), 1);
    check("add_rd1", 32'(o_rd1), 2);
    check("add_wra", 32'(o_wra), 3);
    check("add_src", 32'({o_src1, o_src2}), 0);
    check("add_wr_data", 32'(o_wr_data), 'h000C);
    check("add_wr_cnt", 32'(wr_cnt), 1);
    check("add_pc", 32'(o_pc), 'h02);

    // NOT r2,r5
    run_instr(16'h1428, 16'hFFFA, 1'b0, 1'b0);
    check("not_aluop", 32'(o_aluop), 'h1);
    check("not_rd1", 32'(o_rd1), 5);
    check("not_wra", 32'(o_wra), 2);
    check("not_wr_data", 32'(o_wr_data), 'hFFFA);
    check("not_pc", 32'(o_pc), 'h03);

    // ADDI r4,r1,-1
    run_instr(16'h987F, 16'h0004, 1'b0, 1'b0);
    check("addi_aluop", 32'(o_aluop), 'h0);
    check("addi_src", 32'({o_src1, o_src2}), 'b01);
    check("addi_imm", 32'(o_imm), 'hFFFF);
    check("addi_wra", 32'(o_wra), 4);
    check("addi_wr_data", 32'(o_wr_data), 'h0004);
    check("addi_pc", 32'(o_pc), 'h04);

    // Undefined opcode B
    run_instr(16'hB000, 16'h1234, 1'b0, 1'b0);
    check("ill_pulse", 32'(o_illegal), 1);
    check("ill_retire", 32'(o_retire), 1);
    check("ill_wr_cnt", 32'(wr_cnt), 0);
    check("ill_pc", 32'(o_pc), 'h05);

    // BNEZ r0,+3 not taken, then taken
    run_instr(16'h7003, 16'h0000, 1'b0, 1'b0);
    check("bnez_nt_aluop", 32'(o_aluop), 'h7);
    check("bnez_nt_wr_cnt", 32'(wr_cnt), 0);
    check("bnez_nt_pc", 32'(o_pc), 'h06);
    run_instr(16'h7003, 16'h0000, 1'b1, 1'b0);
    check("bnez_t_pc", 32'(o_pc), 'h0A);
    check("bnez_t_retire", 32'(ret_cnt), 1);

    // BEQZ r0,-2 from pc=0 wraps to 0xFF
    do_reset();
    run_instr(16'h603E, 16'h0000, 1'b1, 1'b0);
    check("beqz_aluop", 32'(o_aluop), 'h6);
    check("beqz_wr_cnt", 32'(wr_cnt), 0);
    check("beqz_pc", 32'(o_pc), 'hFF);

    // ADD with signed overflow
    run_instr(16'h0650, 16'h8000, 1'b0, 1'b1);
`ifdef OVF_TRAP_EN
    check("ovf_wr_cnt", 32'(wr_cnt), 0);
    check("ovf_ret_cnt", 32'(ret_cnt), 0);
    check("ovf_trap", 32'(o_trap), 1);
    check("ovf_halted", 32'(o_halted), 1);
    check("ovf_state", 32'(o_state), 5);
    check("ovf_req", 32'(o_req), 0);
    do_reset();
    check("trap_rst_trap", 32'(trap), 0);
    check("trap_rst_pc", 32'(pc), 'h00);
`else
    check("ovf_wr_cnt", 32'(wr_cnt), 1);
    check("ovf_wr_data", 32'(o_wr_data), 'h8000);
    check("ovf_trap", 32'(o_trap), 0);
    check("ovf_halted", 32'(o_halted), 0);
    check("ovf_pc", 32'(o_pc), 'h00);
`endif
    ovf = 1'b0;

    // HALT, then stray instr_valid must be ignored
    run_instr(16'hF000, 16'h0000, 1'b0, 1'b0);
    check("halt_retire", 32'(o_retire), 1);
    check("halt_wr_cnt", 32'(wr_cnt), 0);
    check("halt_halted", 32'(o_halted), 1);
    check("halt_req", 32'(o_req), 0);
    check("halt_state", 32'(o_state), 4);
    instr = 16'hA205;
    instr_valid = 1'b1;
    bad_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!halted || instr_req || pc != 8'h01 || wr_en || retire) bad_cyc++;
    end
    instr_valid = 1'b0;
    check("halt_hold", 32'(bad_cyc), 0);
    do_reset();
    check("halt_rst_pc", 32'(pc), 'h00);
    check("halt_rst_req", 32'(instr_req), 1);
    check("halt_rst_halted", 32'(halted), 0);

    // Reset in EXEC aborts the instruction
    wr_cnt = 0;
    ret_cnt = 0;
    instr = 16'hA205;
    result = 16'h0005;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tally();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tally();
    end
    check("abort_wr_cnt", 32'(wr_cnt), 0);
    check("abort_ret_cnt", 32'(ret_cnt), 0);
    check("abort_pc", 32'(pc), 'h00);
    check("abort_req", 32'(instr_req), 1);

    // Fetch resumes normally after the abort
    run_instr(16'hA205, 16'h0005, 1'b0, 1'b0);
    check("resume_wr_data", 32'(o_wr_data), 'h0005);
    check("resume_pc", 32'(o_pc), 'h01);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
